// File: rtl/arb_pkg.sv
// Shared state encodings and default limits for the round-robin bus arbiter.
package arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam int DEF_MAX_HOLD = 64;
  localparam int DEF_TIMEOUT  = 255;

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between the bus masters, the slave ready lines and the arbiter.
interface rr_bus_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int N_SLAVES  = 3
);
  localparam int MSEL_W = $clog2(N_MASTERS);

  // Handshake: breq is a level request held by a master until it sees its
  // bgrant bit; the grant stays while breq stays high (or until a hold-limit
  // preemption). Ownership changes only after a drain phase in which every
  // sready bit is 1. msel/bgrant/busy/preempt/timeout_err are registered.
  logic [N_MASTERS-1:0] breq;
  logic [N_SLAVES-1:0]  sready;
  logic [N_MASTERS-1:0] bgrant;
  logic [MSEL_W-1:0]    msel;
  logic                 busy;
  logic                 preempt;
  logic                 timeout_err;
  logic [1:0]           state;

  modport master (
    input  breq, sready,
    output bgrant, msel, busy, preempt, timeout_err, state
  );

  modport slave (
    output breq, sready,
    input  bgrant, msel, busy, preempt, timeout_err, state
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  int pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(ptr) + i) % N;
      if (!any && req[W'(pos)]) begin
        any          = 1'b1;
        gnt[W'(pos)] = 1'b1;
        idx          = W'(pos);
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with bounded hold and a slave-ready drain phase.
// Define ARB_TIMEOUT_EN to bound the drain phase to TIMEOUT cycles.
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int N_SLAVES  = 3,
  parameter int MAX_HOLD  = DEF_MAX_HOLD,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  rr_bus_arbiter_if.master    bus
);

  localparam int MSEL_W = $clog2(N_MASTERS);
  localparam int HOLD_W = $clog2(MAX_HOLD);

  logic [1:0]           state, state_nxt;
  logic [MSEL_W-1:0]    owner;
  logic [MSEL_W-1:0]    ptr;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [N_MASTERS-1:0] bgrant;
  logic                 busy;
  logic                 preempt;
  logic                 timeout_err;

  logic [N_MASTERS-1:0] pick_gnt;
  logic [MSEL_W-1:0]    pick_idx;
  logic                 pick_any;
  logic [N_MASTERS-1:0] owner_mask;
  logic                 bus_ready;
  logic                 owner_req;
  logic                 others_req;
  logic                 hold_max;
  logic                 drain_tmo;
  logic                 drain_done;
  logic                 do_grant;
  logic                 do_preempt;

  rr_pick #(
    .N (N_MASTERS),
    .W (MSEL_W)
  ) u_pick (
    .req (bus.breq),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign bus_ready  = &bus.sready;
  assign owner_mask = N_MASTERS'(1) << owner;
  assign owner_req  = |(bus.breq & owner_mask);
  assign others_req = |(bus.breq & ~owner_mask);
  assign hold_max   = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

`ifdef ARB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  // Drain counter restarts on every entry into RELEASE; it never passes
  // TIMEOUT because RELEASE is always left at that count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != ST_RELEASE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign drain_tmo = (state == ST_RELEASE) && !bus_ready &&
                     (wait_cnt == WAIT_W'(TIMEOUT));
`else
  assign drain_tmo = 1'b0;
`endif

  assign drain_done = bus_ready || drain_tmo;

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_preempt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nxt = ST_GRANT;
          do_grant  = 1'b1;
        end
      end
      ST_GRANT: begin
        // An owner dropping its request wins over hold expiry: no preempt.
        if (!owner_req) begin
          state_nxt = ST_RELEASE;
        end else if (hold_max && others_req) begin
          state_nxt  = ST_RELEASE;
          do_preempt = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (drain_done) begin
          if (pick_any) begin
            state_nxt = ST_GRANT;
            do_grant  = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= '0;
      ptr         <= '0;
      hold_cnt    <= '0;
      bgrant      <= '0;
      busy        <= 1'b0;
      preempt     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != ST_IDLE);
      preempt     <= do_preempt;
      timeout_err <= drain_tmo;
      if (do_grant) begin
        owner    <= pick_idx;
        bgrant   <= pick_gnt;
        hold_cnt <= '0;
        // Pointer moves past the winner so it becomes last in rotation.
        ptr      <= (pick_idx == MSEL_W'(N_MASTERS - 1)) ? '0 : pick_idx + MSEL_W'(1);
      end else begin
        if (state_nxt != ST_GRANT) begin
          bgrant <= '0;
        end
        if (state == ST_GRANT && !hold_max) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end
    end
  end

  assign bus.bgrant      = bgrant;
  assign bus.msel        = owner;
  assign bus.busy        = busy;
  assign bus.preempt     = preempt;
  assign bus.timeout_err = timeout_err;
  assign bus.state       = state;

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Round-robin bus arbiter for the shared system bus; it generalises master arbitration to N masters with fair rotation, a bounded-hold preemption rule and a slave-ready drain phase between ownerships. It sits between the masters' request/grant lines and the bus mux: `msel` steers the master-side mux and `bgrant` enables the owning master. It replaces fixed-priority arbitration where more than two masters share the bus.

## Interface
- `N_MASTERS`, 4: number of requesting masters (2..8)
- `N_SLAVES`, 3: number of slave ready inputs
- `MAX_HOLD`, 64: cycles an owner may hold the bus while others wait (>=2)
- `TIMEOUT`, 255: drain-phase cycle limit; used only with `ARB_TIMEOUT_EN`
- `MSEL_W`, derived localparam: `$clog2(N_MASTERS)`
- `clk`  in  1  bus clock, rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `breq`  in  N_MASTERS  bus request, one bit per master, level
- `sready`  in  N_SLAVES  slave ready; the bus is ready when all bits are 1
- `bgrant`  out  N_MASTERS  one-hot grant or all-zero, registered
- `msel`  out  MSEL_W  index of current or last owner, registered
- `busy`  out  1  high in GRANT or RELEASE
- `preempt`  out  1  one-cycle pulse when the owner is forced off by `MAX_HOLD`
- `timeout_err`  out  1  one-cycle pulse on drain timeout; tied 0 without the macro

## Operation
- States: IDLE, GRANT, RELEASE. Internal registers: `owner`, RR pointer `ptr`, `hold_cnt`, `wait_cnt`.
- Winner selection: the first requesting master at or after `ptr`, searching upward and wrapping modulo N_MASTERS. On every grant, `ptr <= winner+1` (with wrap).
- IDLE:
  - If any `breq` is high, go to GRANT with `owner = winner`. This transition does not check `sready`.
  - Otherwise stay in IDLE.
- GRANT:
  - `bgrant[owner]=1`, `msel=owner`.
  - `hold_cnt` increments each cycle and saturates at MAX_HOLD-1.
  - Go to RELEASE if `breq[owner]` is 0.
  - Also go to RELEASE if `hold_cnt==MAX_HOLD-1` and any other `breq` is high; `preempt` pulses on that transition.
  - A lone requester is never preempted.
- RELEASE:
  - `bgrant` is all zero; `msel` holds `owner`; `wait_cnt` increments.
  - When all `sready` bits are 1: if any `breq` is high, go to GRANT with a new winner; otherwise go to IDLE.
  - The former owner is eligible again but is last in rotation.
- `msel` retains the last owner in IDLE. `hold_cnt` clears on entry to GRANT. `wait_cnt` clears on entry to RELEASE.
- Simultaneous events: owner drop and hold expiry in the same cycle count as a normal release, with no `preempt`. Requests arriving during RELEASE are sampled on the exit cycle only.

## Timing
- Reset (async assert): state IDLE, `bgrant=0`, `msel=0`, `busy=0`, `preempt=0`, `timeout_err=0`, `ptr=0`, counters 0. Reset deassertion is synchronised externally.
- Grant latency: `breq` high before edge k gives `bgrant` high after edge k (1 cycle from IDLE).
- Handover:
  - Owner drops `breq` before edge k: RELEASE after edge k.
  - With `sready` all 1, the next grant comes after edge k+1, giving a minimum 1 dead cycle.
- Reset mid-operation: the grant drops asynchronously; no pulse outputs fire.
- A master must keep `breq` high until it sees `bgrant`. Dropping `breq` early just removes it from selection.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - In RELEASE, when `wait_cnt==TIMEOUT` and `sready` is not all 1, `timeout_err` pulses for one cycle.
  - The arbiter then exits RELEASE as if ready.
- `ARB_TIMEOUT_EN` undefined: RELEASE waits indefinitely, `timeout_err` is constant 0, and `wait_cnt` is not built.

## Structure
- Shared package `arb_pkg`: state encodings (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2) and the default constants for MAX_HOLD and TIMEOUT.
- Sub-module `rr_pick`: combinational rotating priority picker (`req`, `ptr` → one-hot `gnt`, index `idx`, `any`), instantiated once.

## Test plan
- Reset with `breq=4'b0101` held: outputs 0. Release reset → `bgrant=0001`, `msel=0` one cycle later.
- All four requesting, each owner dropping `breq` after 3 grant cycles, `sready` all 1: grant order 0,1,2,3,0 with 1 dead cycle between grants.
- `breq=0011`, master 0 never drops, MAX_HOLD=4: `preempt` pulses after 4 grant cycles, then `bgrant=0010`.
- Only master 2 requesting for 200 cycles: `bgrant=0100` throughout, no `preempt`.
- Owner releases with `sready=011` held low for 10 cycles: `bgrant=0`, `msel` stable, `busy=1`, then the grant issues on the cycle after `sready=111`.
- `ARB_TIMEOUT_EN`, TIMEOUT=8, `sready` stuck at 0: `timeout_err` pulses once, then the next requester is granted or the arbiter returns to IDLE.
